// File: rtl/posit_accum_seq_pkg.sv
// Shared posit definitions for the accumulation sequencer: default widths,
// special encodings and the sequencer state codes.
package posit_pkg;

    localparam int POSIT_N  = 32;
    localparam int POSIT_ES = 2;

    localparam logic [POSIT_N-1:0] NAR  = 32'h8000_0000;
    localparam logic [POSIT_N-1:0] ZERO = 32'h0000_0000;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_FIRST = 3'd0;
    localparam seq_state_t ST_NEXT  = 3'd1;
    localparam seq_state_t ST_ISSUE = 3'd2;
    localparam seq_state_t ST_WAIT  = 3'd3;
    localparam seq_state_t ST_OUT   = 3'd4;

    // Saturating increment for the 16-bit term counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/posit_accum_seq_if.sv
// Bundles the operand stream, the result stream and the shared-adder
// start/done handshake seen by the accumulation sequencer.
interface posit_accum_seq_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         in_last;

    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_nar;
    logic         out_zero;
    logic         out_timeout;
    logic [15:0]  out_count;

    logic         add_start;
    logic [N-1:0] add_in1;
    logic [N-1:0] add_in2;
    logic [N-1:0] add_result;
    logic         add_inf;
    logic         add_zero;
    logic         add_done;

    modport master (
        input  in_valid, in_data, in_last, out_ready,
               add_result, add_inf, add_zero, add_done,
        output in_ready, out_valid, out_data, out_nar, out_zero,
               out_timeout, out_count, add_start, add_in1, add_in2
    );

    modport slave (
        output in_valid, in_data, in_last, out_ready,
               add_result, add_inf, add_zero, add_done,
        input  in_ready, out_valid, out_data, out_nar, out_zero,
               out_timeout, out_count, add_start, add_in1, add_in2
    );

endinterface

// File: rtl/posit_accum_seq_detect.sv
// Combinational classification of an N-bit posit as zero or NaR.
module posit_special_detect #(
    parameter int N = 32
) (
    input  logic [N-1:0] posit_i,
    output logic         is_zero_o,
    output logic         is_nar_o
);

    localparam logic [N-1:0] NAR_PAT = {1'b1, {(N-1){1'b0}}};

    assign is_zero_o = (posit_i == {N{1'b0}});
    assign is_nar_o  = (posit_i == NAR_PAT);

endmodule

// File: rtl/posit_accum_seq.sv
// Accumulation sequencer: absorbs a stream of posit terms, drives one shared
// adder per extra term and reports the final sum with NaR/zero/timeout status.
module posit_accum_seq
    import posit_pkg::*;
#(
    parameter int N       = POSIT_N,
    parameter int ES      = POSIT_ES,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    posit_accum_seq_if.master bus
);

    localparam int           TW      = $clog2(TIMEOUT + 1);
    localparam logic [N-1:0] NAR_PAT = {1'b1, {(N-1){1'b0}}};
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    seq_state_t    state_q, state_d;
    logic [N-1:0]  acc_q, acc_d;
    logic          nar_q, nar_d;
    logic          tmo_q, tmo_d;
    logic [15:0]   count_q, count_d;
    logic [N-1:0]  in1_q, in1_d;
    logic [N-1:0]  in2_q, in2_d;
    logic          last_q, last_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic          in_ready_q, add_start_q, out_valid_q;
    logic [N-1:0]  out_data_q;
    logic          out_nar_q, out_timeout_q;
    logic [15:0]   out_count_q;

    logic in_zero_s, in_nar_s, acc_zero_s, acc_nar_s;
    logic accept_s;
    logic unused_s;

    posit_special_detect #(.N(N)) u_in_det (
        .posit_i   (bus.in_data),
        .is_zero_o (in_zero_s),
        .is_nar_o  (in_nar_s)
    );

    posit_special_detect #(.N(N)) u_acc_det (
        .posit_i   (acc_q),
        .is_zero_o (acc_zero_s),
        .is_nar_o  (acc_nar_s)
    );

    assign unused_s = ^{in_zero_s, bus.add_zero};
    assign accept_s = bus.in_valid & in_ready_q;

    // Next-state and datapath decisions for the sequencer.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        nar_d   = nar_q;
        tmo_d   = tmo_q;
        count_d = count_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        last_d  = last_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_FIRST: begin
                if (accept_s) begin
                    acc_d   = bus.in_data;
                    count_d = 16'd1;
                    nar_d   = in_nar_s;
                    state_d = bus.in_last ? ST_OUT : ST_NEXT;
                end else begin
                    state_d = ST_FIRST;
                end
            end
            ST_NEXT: begin
                if (accept_s) begin
                    count_d = sat_inc16(count_q);
                    // NaR is absorbing, so the adder is bypassed entirely.
                    if (acc_nar_s || in_nar_s) begin
                        acc_d   = NAR_PAT;
                        nar_d   = 1'b1;
                        state_d = bus.in_last ? ST_OUT : ST_NEXT;
                    end else begin
                        in1_d   = acc_q;
                        in2_d   = bus.in_data;
                        last_d  = bus.in_last;
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_ISSUE: begin
                tcnt_d  = TW'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.add_done) begin
                    acc_d   = bus.add_result;
                    nar_d   = nar_q | bus.add_inf;
                    state_d = last_q ? ST_OUT : ST_NEXT;
                end else if (tcnt_q >= TMO_LAST) begin
                    acc_d   = NAR_PAT;
                    nar_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = last_q ? ST_OUT : ST_NEXT;
                end else begin
                    tcnt_d  = tcnt_q + TW'(1);
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    nar_d   = 1'b0;
                    tmo_d   = 1'b0;
                    count_d = 16'd0;
                    state_d = ST_FIRST;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_FIRST;
            end
        endcase
    end

    // Sequencer state, accumulator and held adder operands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FIRST;
            acc_q   <= {N{1'b0}};
            nar_q   <= 1'b0;
            tmo_q   <= 1'b0;
            count_q <= 16'd0;
            in1_q   <= {N{1'b0}};
            in2_q   <= {N{1'b0}};
            last_q  <= 1'b0;
            tcnt_q  <= {TW{1'b0}};
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            nar_q   <= nar_d;
            tmo_q   <= tmo_d;
            count_q <= count_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Output registers: handshakes track the next state, result fields are
    // captured on entry to OUT and cleared once the result is consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_q    <= 1'b0;
            add_start_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= {N{1'b0}};
            out_nar_q     <= 1'b0;
            out_timeout_q <= 1'b0;
            out_count_q   <= 16'd0;
        end else begin
            in_ready_q  <= (state_d == ST_FIRST) || (state_d == ST_NEXT);
            add_start_q <= (state_d == ST_ISSUE);
            out_valid_q <= (state_d == ST_OUT);
            if ((state_d == ST_OUT) && (state_q != ST_OUT)) begin
                out_data_q    <= acc_d;
                out_nar_q     <= nar_d;
                out_timeout_q <= tmo_d;
                out_count_q   <= count_d;
            end else if (state_d != ST_OUT) begin
                out_data_q    <= {N{1'b0}};
                out_nar_q     <= 1'b0;
                out_timeout_q <= 1'b0;
                out_count_q   <= 16'd0;
            end else begin
                out_data_q    <= out_data_q;
                out_nar_q     <= out_nar_q;
                out_timeout_q <= out_timeout_q;
                out_count_q   <= out_count_q;
            end
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.add_start   = add_start_q;
    assign bus.add_in1     = in1_q;
    assign bus.add_in2     = in2_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_nar     = out_nar_q;
    // acc_q cannot change while in OUT, so this flag is as stable as the rest.
    assign bus.out_zero    = out_valid_q & acc_zero_s;
    assign bus.out_timeout = out_timeout_q;
    assign bus.out_count   = out_count_q;

endmodule

// File: tb/tb_posit_accum_seq.sv
// Directed bench for posit_accum_seq with a behavioural stub adder.
module tb_posit_accum_seq;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    posit_accum_seq_if #(.N(32)) bus ();

    posit_accum_seq #(.N(32), .ES(2), .TIMEOUT(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stub adder controls (written by the stimulus) and observations (by the stub).
    int          stub_lat    = 3;
    bit          stub_en     = 1'b0;
    logic [31:0] stub_result = 32'h0;
    int          inject_req  = 0;
    int          inject_ack  = 0;
    int          start_cnt   = 0;
    int          start_cyc   = 0;
    int          stab_err    = 0;
    int          wait_n      = 0;
    bit          busy        = 1'b0;
    logic [31:0] in1_cap     = 32'h0;
    logic [31:0] in2_cap     = 32'h0;

    always @(negedge clk) begin
        bus.add_done   = 1'b0;
        bus.add_inf    = 1'b0;
        bus.add_zero   = 1'b0;
        if (inject_req != inject_ack) begin
            inject_ack     = inject_req;
            bus.add_done   = 1'b1;
            bus.add_inf    = 1'b1;
            bus.add_result = 32'h1234_5678;
        end else if (bus.add_start) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
            busy      = 1'b1;
            wait_n    = 0;
            in1_cap   = bus.add_in1;
            in2_cap   = bus.add_in2;
        end else if (busy) begin
            if (bus.add_in1 !== in1_cap || bus.add_in2 !== in2_cap) stab_err = stab_err + 1;
            if (stub_en) begin
                wait_n = wait_n + 1;
                if (wait_n == stub_lat) begin
                    bus.add_done   = 1'b1;
                    bus.add_result = stub_result;
                    busy           = 1'b0;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        for (int i = 0; i < 300; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            check_eq("send_timeout", 32'd0, 32'd1);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_out(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("out_timeout_wait", 32'd0, 32'd1);
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    int s0;
    int out_cyc;
    bit bp_bad;
    logic [31:0] bp_data;

    initial begin
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
        bus.in_last  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("rst_out_data",  bus.out_data,           32'd0);
        check_eq("rst_add_start", {31'd0, bus.add_start}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Single term, one cycle to out_valid, no add
        s0 = start_cnt;
        send(32'h4000_0000, 1'b1);
        @(negedge clk);
        check_eq("single_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("single_data",  bus.out_data,           32'h4000_0000);
        check_eq("single_count", {16'd0, bus.out_count}, 32'd1);
        check_eq("single_nar",   {31'd0, bus.out_nar},   32'd0);
        check_eq("single_zero",  {31'd0, bus.out_zero},  32'd0);
        check_eq("single_starts", start_cnt - s0,        32'd0);
        consume();

        // Two terms through the adder
        stub_en = 1'b1; stub_lat = 3; stub_result = 32'h5768_8701;
        s0 = start_cnt; stab_err = 0;
        send(32'h5AD9_A053, 1'b0);
        send(32'hB36A_8CB6, 1'b1);
        wait_out(100);
        check_eq("two_starts",  start_cnt - s0,         32'd1);
        check_eq("two_in1",     in1_cap,                32'h5AD9_A053);
        check_eq("two_in2",     in2_cap,                32'hB36A_8CB6);
        check_eq("two_stable",  stab_err,               32'd0);
        check_eq("two_data",    bus.out_data,           32'h5768_8701);
        check_eq("two_count",   {16'd0, bus.out_count}, 32'd2);
        check_eq("two_tmo",     {31'd0, bus.out_timeout}, 32'd0);
        consume();

        // NaR propagation bypasses the adder
        s0 = start_cnt;
        send(32'h4000_0000, 1'b0);
        send(32'h8000_0000, 1'b0);
        send(32'h4000_0000, 1'b1);
        wait_out(20);
        check_eq("nar_starts", start_cnt - s0,         32'd0);
        check_eq("nar_data",   bus.out_data,           32'h8000_0000);
        check_eq("nar_flag",   {31'd0, bus.out_nar},   32'd1);
        check_eq("nar_count",  {16'd0, bus.out_count}, 32'd3);
        consume();

        // Adder never answers: timeout
        stub_en = 1'b0;
        s0 = start_cnt;
        send(32'h4000_0000, 1'b0);
        send(32'h4000_0000, 1'b1);
        wait_out(200);
        out_cyc = cyc;
        check_eq("tmo_starts",  start_cnt - s0,          32'd1);
        check_eq("tmo_latency", out_cyc - start_cyc,     32'd64);
        check_eq("tmo_flag",    {31'd0, bus.out_timeout}, 32'd1);
        check_eq("tmo_data",    bus.out_data,            32'h8000_0000);
        check_eq("tmo_nar",     {31'd0, bus.out_nar},    32'd1);
        inject_req = inject_req + 1;
        repeat (3) @(negedge clk);
        check_eq("stray_valid", {31'd0, bus.out_valid},  32'd1);
        check_eq("stray_data",  bus.out_data,            32'h8000_0000);
        check_eq("stray_count", {16'd0, bus.out_count},  32'd2);
        consume();
        @(negedge clk);
        check_eq("tmo_cleared", {31'd0, bus.out_timeout}, 32'd0);

        // Backpressure on the result
        send(32'h3000_0000, 1'b1);
        @(negedge clk);
        bp_data = bus.out_data;
        bp_bad  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!bus.out_valid || bus.out_data !== 32'h3000_0000 || bus.in_ready) bp_bad = 1'b1;
            @(negedge clk);
        end
        check_eq("bp_hold", {31'd0, bp_bad}, 32'd0);
        check_eq("bp_data", bp_data,         32'h3000_0000);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check_eq("bp_consumed", {31'd0, bus.out_valid}, 32'd0);
        check_eq("bp_in_ready", {31'd0, bus.in_ready},  32'd1);

        // Reset while waiting on the adder, then a stale done
        s0 = start_cnt;
        send(32'h4000_0000, 1'b0);
        send(32'h3800_0000, 1'b1);
        repeat (5) @(negedge clk);
        check_eq("wait_in_ready", {31'd0, bus.in_ready}, 32'd0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        inject_req = inject_req + 1;
        repeat (4) @(negedge clk);
        check_eq("rstw_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check_eq("rstw_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("rstw_count",     {16'd0, bus.out_count}, 32'd0);
        check_eq("rstw_starts",    start_cnt - s0,         32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/posit_accum_seq.md
Name: posit_accum_seq

Overview:
- Initiator/sequencer for the posit adder's start/done interface. Consumes a stream of posit operands over valid/ready and issues one adder operation per additional term.
- Holds adder operands stable until done, and folds each result back into a running accumulator.
- Emits the final sum, with NaR/zero/timeout status, when the term flagged last has been absorbed.
- Sits between the PairHMM datapath and one shared positadd instance.

Parameters:
- N, 32, posit width.
- ES, 2, posit exponent size (carried for package consistency; no arithmetic performed here).
- TIMEOUT, 64, maximum cycles to wait for add_done after add_start.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  operand accepted when in_valid&in_ready
- in_data  in  N  posit operand
- in_last  in  1  final term of current sum
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid&out_ready
- out_data  out  N  accumulated posit
- out_nar  out  1  result is NaR (0x80000000 for N=32)
- out_zero  out  1  result is zero
- out_timeout  out  1  at least one add timed out in this sum
- out_count  out  16  terms absorbed, saturating at 0xFFFF
- add_start  out  1  one-cycle start pulse to adder
- add_in1  out  N  accumulator operand
- add_in2  out  N  new operand
- add_result  in  N  adder result
- add_inf  in  1  adder NaR flag
- add_zero  in  1  adder zero flag
- add_done  in  1  adder completion

Behaviour:
- Reset (async assert, sync release): state FIRST, all outputs 0, accumulator 0, sticky NaR/timeout cleared, count 0.
- States and transitions:
  - FIRST: in_ready=1. On accept: acc<=in_data, count<=1, nar<=(in_data==NaR). in_last → OUT; else → NEXT. No add issued for the first term.
  - NEXT: in_ready=1. On accept: count++ (saturating).
    - If acc is NaR or in_data is NaR: acc<=NaR, nar<=1, no add. in_last → OUT; else stay NEXT.
    - Otherwise: latch add_in1<=acc, add_in2<=in_data, remember last flag, → ISSUE.
  - ISSUE: add_start=1 for exactly this cycle; in_ready=0; → WAIT.
  - WAIT: in_ready=0; add_in1/add_in2 held stable; timeout counter increments from 1.
    - On add_done: acc<=add_result; nar|=add_inf. Latched last → OUT; else → NEXT.
    - If the counter reaches TIMEOUT with no done: acc<=NaR, nar<=1, timeout<=1, then take the same last/next branch.
  - OUT: out_valid=1. out_data=acc, out_nar=nar, out_zero=(acc==0), out_timeout, out_count all stable while out_ready=0. On out_ready → FIRST, and nar, timeout and count are cleared.
- add_done is ignored in every state except WAIT, including a stale done arriving after a timeout or after reset.
- in_ready is registered-state based (no combinational path from out_ready).
- add_start is never asserted twice per operation and never while in WAIT.
- Latency:
  - Single-term sum: out_valid 1 cycle after accept.
  - Each add: ISSUE(1) + adder latency + 1 before returning to NEXT/OUT.
- Reset mid-operation aborts the sum silently; no partial result is emitted.

Decomposition:
- Shared package posit_pkg: N/ES defaults, NAR and ZERO constants, state enum (FIRST, NEXT, ISSUE, WAIT, OUT).
- One sub-module, posit_special_detect: combinational is_zero/is_nar of an N-bit posit, instantiated for in_data and acc.
- Timeout counter stays inline.

Test Plan:
- Single term: in_data=0x40000000, in_last=1 → no add_start; out_data=0x40000000, out_count=1, out_nar=0, out_zero=0.
- Two terms: 0x5AD9A053 then 0xB36A8CB6 (last); stub adder returns 0x57688701 with done after 3 cycles → exactly one add_start pulse with add_in1=0x5AD9A053, add_in2=0xB36A8CB6 held until done; out_data=0x57688701, out_count=2.
- NaR propagation: terms 0x40000000, 0x80000000, 0x40000000 (last) → zero add_start pulses after the first term; out_data=0x80000000, out_nar=1, out_count=3.
- Timeout: stub never asserts done, TIMEOUT=64 → out_valid 64 cycles after add_start, out_timeout=1, out_data=0x80000000. A stray add_done injected next is ignored.
- Backpressure: out_ready=0 for 10 cycles → out_valid and out_data stable, in_ready=0 throughout; consumed on the first cycle out_ready=1, then in_ready=1.
- Reset in WAIT: pull reset_n low for 2 cycles, then assert add_done after release → no state change; in_ready=1, out_valid=0, out_count=0.
